router_pkt_reader: RTL

- Destination-side consumer for one output port of the 1x3 router; drains the port FIFO through its read-enable / registered-dout interface.
- Parses each packet: header {len[7:2], addr[1:0]}, len payload bytes, then one parity byte.
- Streams payload out, checks parity and destination address, flags truncated packets.
- Reads within the router's 30-cycle unread window so the port is never soft-reset under normal operation.

---
 rtl/router_pkt_reader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/router_pkt_reader.sv
// Destination-side packet reader for one router output port: drains the port FIFO,
// streams the payload, and checks parity, destination address and truncation.
module router_pkt_reader #(
    parameter logic [1:0] PORT_ID   = 2'd0,
    parameter int         START_DLY = 0,
    parameter int         TIMEOUT   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld_out,
    input  logic [7:0]  din,
    output logic        re,
    output logic [7:0]  pkt_data,
    output logic        pkt_data_vld,
    output logic        sop,
    output logic        eop,
    output logic        pkt_done,
    output logic [5:0]  pkt_len,
    output logic        parity_err,
    output logic        addr_err,
    output logic        trunc_err,
    output logic        busy,
    output logic [15:0] pkt_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [4:0] DLY_LAST   = 5'(START_DLY);
    localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg;
    state_t      state_next;
    logic        rd_pend_reg;
    logic [4:0]  dly_cnt_reg;
    logic [6:0]  issue_reg;
    logic [5:0]  remain_reg;
    logic        first_reg;
    logic [7:0]  parity_reg;
    logic        addr_chk_reg;
    logic [7:0]  stall_cnt_reg;

    logic        accept;
    logic        dly_hit;
    logic        stall_hit;
    logic        hdr_byte;
    logic        payload_byte;
    logic        parity_byte;
    logic        abort;

    assign accept    = re & vld_out;
    assign dly_hit   = (dly_cnt_reg == DLY_LAST);
    assign stall_hit = (stall_cnt_reg == STALL_LAST);
    assign busy      = (state_reg != IDLE);

    // Next-state and read-enable; re is qualified by rst so nothing is popped while held in reset.
    always_comb begin
        state_next   = state_reg;
        re           = 1'b0;
        hdr_byte     = 1'b0;
        payload_byte = 1'b0;
        parity_byte  = 1'b0;
        abort        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (vld_out && dly_hit && rst) begin
                    re         = 1'b1;
                    state_next = HDR;
                end
            end
            HDR: begin
                if (rd_pend_reg) begin
                    hdr_byte   = 1'b1;
                    state_next = BODY;
                end
            end
            BODY: begin
                re = vld_out && (issue_reg != 7'd0) && rst;
                if (rd_pend_reg && (remain_reg == 6'd0)) begin
                    parity_byte = 1'b1;
                    state_next  = DONE;
                end else if (!vld_out && stall_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (rd_pend_reg) begin
                    payload_byte = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend_reg   <= 1'b0;
            dly_cnt_reg   <= '0;
            issue_reg     <= '0;
            remain_reg    <= '0;
            first_reg     <= 1'b0;
            parity_reg    <= '0;
            addr_chk_reg  <= 1'b0;
            stall_cnt_reg <= '0;
            pkt_data      <= '0;
            pkt_data_vld  <= 1'b0;
            sop           <= 1'b0;
            eop           <= 1'b0;
            pkt_done      <= 1'b0;
            pkt_len       <= '0;
            parity_err    <= 1'b0;
            addr_err      <= 1'b0;
            trunc_err     <= 1'b0;
            pkt_count     <= '0;
        end else begin
            rd_pend_reg  <= accept;
            pkt_data_vld <= 1'b0;
            sop          <= 1'b0;
            eop          <= 1'b0;
            pkt_done     <= 1'b0;
            trunc_err    <= 1'b0;

            // Start delay restarts whenever vld_out drops before it expires.
            if ((state_reg == IDLE) && vld_out && !dly_hit) begin
                dly_cnt_reg <= dly_cnt_reg + 5'd1;
            end else begin
                dly_cnt_reg <= '0;
            end

            if (hdr_byte) begin
                parity_reg    <= din;
                addr_chk_reg  <= (din[1:0] != PORT_ID);
                issue_reg     <= {1'b0, din[7:2]} + 7'd1;
                remain_reg    <= din[7:2];
                pkt_len       <= din[7:2];
                first_reg     <= 1'b1;
                stall_cnt_reg <= '0;
            end

            if (state_reg == BODY) begin
                if (accept) begin
                    issue_reg     <= issue_reg - 7'd1;
                    stall_cnt_reg <= '0;
                end else if (!vld_out) begin
                    stall_cnt_reg <= stall_cnt_reg + 8'd1;
                end
            end

            if (payload_byte) begin
                parity_reg   <= parity_reg ^ din;
                pkt_data     <= din;
                pkt_data_vld <= 1'b1;
                sop          <= first_reg;
                eop          <= (remain_reg == 6'd1);
                remain_reg   <= remain_reg - 6'd1;
                first_reg    <= 1'b0;
            end

            if (parity_byte) begin
                pkt_done   <= 1'b1;
                parity_err <= (parity_reg != din);
                addr_err   <= addr_chk_reg;
                pkt_count  <= pkt_count + 16'd1;
            end

            if (abort) begin
                trunc_err <= 1'b1;
            end
        end
    end

endmodule
